block_mem_responder: RTL and testbench
======================================

BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

Interface
- REQ-001: Parameter ADDR_SIZE, default 30, word address width.
- REQ-002: Parameter WORD_SIZE, default 32, bits per word.
- REQ-003: Parameter BLOCK_OFFSET_BITS, default 2, log2 words per line; LINE_BITS = WORD_SIZE * 2**BLOCK_OFFSET_BITS.
- REQ-004: Parameter MEM_INDEX_BITS, default 8, log2 lines stored.
- REQ-005: Parameter LATENCY, default 3, accept-to-ready cycles; legal range 1..255.
- REQ-006: clk  input  1  single clock, all state on posedge.
- REQ-007: rst  input  1  reset, asynchronous, active-high.
- REQ-008: mem_r  input  1  line-read request from cache, level, held until ready seen.
- REQ-009: mem_w  input  1  line-write (write-back) request from cache, level, held until ready seen.
- REQ-010: line_addr  input  ADDR_SIZE-BLOCK_OFFSET_BITS  line address of request.
- REQ-011: ready  output  1  one-cycle completion pulse to cache.
- REQ-012: mem_data  inout  LINE_BITS  line data; cache drives on write, this block drives on read only.
- REQ-013: err  output  1  sticky protocol-error flag.
- REQ-014: rd_count, wr_count  output  16 each  completed read/write counts.

Function
- REQ-015: Storage SHALL be 2**MEM_INDEX_BITS lines of LINE_BITS, initialised to zero at time zero, not cleared by rst.
- REQ-016: Line index SHALL be line_addr[MEM_INDEX_BITS-1:0]; upper bits ignored (aliasing by design).
- REQ-017: FSM states SHALL be IDLE, BUSY, RESP, RELEASE.
- REQ-018: IDLE: exactly one of mem_r/mem_w high at posedge -> accept: latch op, index, and (for write) mem_data; load counter LATENCY-1; go BUSY.
- REQ-019: IDLE with mem_r and mem_w both high SHALL not accept, SHALL set err, SHALL stay IDLE.
- REQ-020: BUSY: counter decrements each cycle; when counter is 0 go RESP (LATENCY=1 -> RESP on the next edge after accept).
- REQ-021: ready SHALL be high exactly during RESP, i.e. one cycle, rising LATENCY edges after the accepting edge.
- REQ-022: Write: latched line SHALL be committed to storage at the edge entering RESP; wr_count increments at the same edge.
- REQ-023: Read: mem_data SHALL be driven with stored line from the edge entering RESP, through RELEASE, until the edge at which mem_r is sampled low; otherwise high-Z; rd_count increments at the RESP-entry edge.
- REQ-024: mem_data SHALL never be driven while latched op is write or in IDLE/BUSY.
- REQ-025: RESP -> RELEASE unconditionally; RELEASE -> IDLE when the latched request line is sampled low; no new accept while in RELEASE.
- REQ-026: Request line dropped or changed during BUSY SHALL not abort the transaction; latched op/index/data are used.
- REQ-027: Counters SHALL wrap 0xFFFF -> 0x0000.
- REQ-028: Read after write to same index SHALL return the written line.

Reset
- REQ-029: rst high SHALL asynchronously force IDLE, ready=0, err=0, rd_count=0, wr_count=0, counter=0, mem_data high-Z.
- REQ-030: rst during BUSY SHALL discard pending write; storage unchanged.
- REQ-031: First accept possible at first posedge after rst deasserts.

Verification
- REQ-032: LATENCY=3; mem_w=1, line_addr=0x05, mem_data=0xDEAD_BEEF_0123_4567_89AB_CDEF_0000_1111 accepted edge N -> ready high one cycle from edge N+3; wr_count=1.
- REQ-033: Then mem_w=0, mem_r=1, line_addr=0x105 -> same data driven on mem_data when ready high (alias); rd_count=1; high-Z after mem_r drops.
- REQ-034: mem_r and mem_w both high in IDLE -> no ready, err=1 stays set until rst.
- REQ-035: rst pulse one cycle after accepting write to index 0x07 -> ready never asserted; later read of 0x07 returns zero.
- REQ-036: mem_r held high 5 cycles after ready -> exactly one ready pulse, no re-accept until mem_r low; LATENCY=1 run shows ready at edge N+1.
- REQ-037: 65536 writes -> wr_count returns to 0x0000.

Source files
------------

// File: rtl/block_mem_responder_if.sv
// block_mem_responder_if
//   Request/response handshake between a cache (master) and the line memory
//   responder (slave). The bidirectional line data bus is not part of this
//   bundle; it is a plain inout port on the responder.
//   mem_r, mem_w : level requests from the cache, held until ready is seen
//   line_addr    : line address of the request
//   ready        : one-cycle completion pulse from the responder
//   err          : sticky protocol-error flag (both requests high in IDLE)
//   rd_count     : completed line reads, wraps at 16 bits
//   wr_count     : completed line writes, wraps at 16 bits
interface block_mem_responder_if #(
    parameter int ADDR_SIZE         = 30,
    parameter int BLOCK_OFFSET_BITS = 2
);
    logic                                  mem_r;
    logic                                  mem_w;
    logic [ADDR_SIZE-BLOCK_OFFSET_BITS-1:0] line_addr;
    logic                                  ready;
    logic                                  err;
    logic [15:0]                           rd_count;
    logic [15:0]                           wr_count;

    modport master (
        output mem_r, mem_w, line_addr,
        input  ready, err, rd_count, wr_count
    );

    modport slave (
        input  mem_r, mem_w, line_addr,
        output ready, err, rd_count, wr_count
    );
endinterface

// File: rtl/block_mem_responder.sv
// block_mem_responder
//   Fixed-latency line memory that answers cache line reads and write-backs.
//   A request is accepted in IDLE, completes LATENCY edges later with a
//   one-cycle ready pulse, then waits in RELEASE for the request to drop.
//   clk      : single clock, all state on posedge
//   rst      : asynchronous active-high reset (storage is not cleared)
//   bus      : handshake/status interface (slave side)
//   mem_data : line data; driven by the cache on write, by this block on read
module block_mem_responder #(
    parameter int ADDR_SIZE         = 30,
    parameter int WORD_SIZE         = 32,
    parameter int BLOCK_OFFSET_BITS = 2,
    parameter int MEM_INDEX_BITS    = 8,
    parameter int LATENCY           = 3
) (
    input  logic                                         clk,
    input  logic                                         rst,
    block_mem_responder_if.slave                         bus,
    inout  wire [WORD_SIZE*(2**BLOCK_OFFSET_BITS)-1:0]   mem_data
);
    localparam int         LINE_BITS = WORD_SIZE * (2 ** BLOCK_OFFSET_BITS);
    localparam int         DEPTH     = 2 ** MEM_INDEX_BITS;
    localparam logic [7:0] CNT_LOAD  = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, RELEASE} state_t;

    state_t                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      op_wr_q, op_wr_d;
    logic [MEM_INDEX_BITS-1:0] idx_q, idx_d;
    logic [LINE_BITS-1:0]      wdata_q, wdata_d;
    logic                      err_q, err_d;
    logic [15:0]               rd_cnt_q, rd_cnt_d;
    logic [15:0]               wr_cnt_q, wr_cnt_d;
    logic                      mem_we;
    logic                      drive_rd;
    logic                      unused_addr;

    // Storage powers up zero and deliberately sits outside the reset domain.
    logic [LINE_BITS-1:0]      mem_q [DEPTH] = '{default: '0};

    // Upper line-address bits alias onto the same index.
    assign unused_addr = ^bus.line_addr;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_wr_d  = op_wr_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        mem_we   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.mem_r && bus.mem_w) begin
                    err_d = 1'b1;
                end else if (bus.mem_r || bus.mem_w) begin
                    op_wr_d = bus.mem_w;
                    idx_d   = bus.line_addr[MEM_INDEX_BITS-1:0];
                    if (bus.mem_w) begin
                        wdata_d = mem_data;
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    // Commit and count on the edge that enters RESP.
                    state_d = RESP;
                    if (op_wr_q) begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 16'd1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                // Only the latched request line matters for release.
                if (op_wr_q ? !bus.mem_w : !bus.mem_r) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_wr_q  <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // mem_we is derived from state_q, which reset holds in IDLE, so a
    // pending write is discarded by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign drive_rd     = !op_wr_q && ((state_q == RESP) || (state_q == RELEASE));
    assign mem_data     = drive_rd ? mem_q[idx_q] : 'z;

    assign bus.ready    = (state_q == RESP);
    assign bus.err      = err_q;
    assign bus.rd_count = rd_cnt_q;
    assign bus.wr_count = wr_cnt_q;
endmodule

// File: tb/tb_block_mem_responder.sv
// tb_block_mem_responder
//   Directed bench for block_mem_responder: one instance at LATENCY=3 and
//   one at LATENCY=1, driven from a single linear initial block. Inputs
//   change on the falling edge; outputs are sampled on the falling edge.
module tb_block_mem_responder;
    localparam int LB = 128;
    localparam logic [LB-1:0] DATA_D = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_1111;
    localparam logic [LB-1:0] DATA_E = 128'h0F0F_0F0F_1234_5678_9ABC_DEF0_5555_AAAA;
    localparam logic [LB-1:0] DATA_F = 128'hCAFE_F00D_0000_0001_8000_0000_FFFF_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    block_mem_responder_if #(.ADDR_SIZE(30), .BLOCK_OFFSET_BITS(2)) ifa ();
    block_mem_responder_if #(.ADDR_SIZE(30), .BLOCK_OFFSET_BITS(2)) ifb ();

    wire  [LB-1:0] md_a;
    wire  [LB-1:0] md_b;
    logic          drv_a = 1'b0;
    logic          drv_b = 1'b0;
    logic [LB-1:0] dat_a = '0;
    logic [LB-1:0] dat_b = '0;

    assign md_a = drv_a ? dat_a : 'z;
    assign md_b = drv_b ? dat_b : 'z;

    block_mem_responder #(
        .ADDR_SIZE(30), .WORD_SIZE(32), .BLOCK_OFFSET_BITS(2),
        .MEM_INDEX_BITS(8), .LATENCY(3)
    ) u_dut_a (
        .clk(clk), .rst(rst), .bus(ifa), .mem_data(md_a)
    );

    block_mem_responder #(
        .ADDR_SIZE(30), .WORD_SIZE(32), .BLOCK_OFFSET_BITS(2),
        .MEM_INDEX_BITS(8), .LATENCY(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .bus(ifb), .mem_data(md_b)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkl(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // An undriven line bus reads as Z in a 4-state simulator and as zero in
    // a 2-state one; either counts as released.
    function automatic logic relz(input logic [LB-1:0] v);
        return (v === {LB{1'bz}}) || (v === {LB{1'b0}});
    endfunction

    // Full LATENCY=1 write on instance B, ready checked on its exact edge.
    task automatic write_b(input logic [27:0] addr, input logic [LB-1:0] data, input string tag);
        ifb.mem_w = 1'b1; ifb.line_addr = addr; dat_b = data; drv_b = 1'b1;
        tick();
        drv_b = 1'b0;
        chk1({tag, "_busy"}, ifb.ready, 1'b0);
        tick();
        chk1({tag, "_ready"}, ifb.ready, 1'b1);
        ifb.mem_w = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        ifa.mem_r = 1'b0; ifa.mem_w = 1'b0; ifa.line_addr = '0;
        ifb.mem_r = 1'b0; ifb.mem_w = 1'b0; ifb.line_addr = '0;

        repeat (2) tick();
        chk1 ("rst_ready", ifa.ready, 1'b0);
        chk1 ("rst_err",   ifa.err,   1'b0);
        chk16("rst_rd",    ifa.rd_count, 16'd0);
        chk16("rst_wr",    ifa.wr_count, 16'd0);
        chk1 ("rst_hiz",   relz(md_a), 1'b1);
        rst = 1'b0;

        // Write 0x05; the first edge after reset release accepts it (edge N).
        ifa.mem_w = 1'b1; ifa.line_addr = 28'h005; dat_a = DATA_D; drv_a = 1'b1;
        tick();
        drv_a = 1'b0; dat_a = '0;
        chk1("w_n0", ifa.ready, 1'b0);
        tick();
        chk1("w_n1", ifa.ready, 1'b0);
        tick();
        chk1("w_n2", ifa.ready, 1'b0);
        tick();
        chk1 ("w_n3_ready", ifa.ready, 1'b1);
        chk16("w_wr_count", ifa.wr_count, 16'd1);
        chk1 ("w_no_drive", relz(md_a), 1'b1);
        ifa.mem_w = 1'b0;
        tick();
        chk1("w_pulse_end", ifa.ready, 1'b0);
        tick();

        // Read 0x105 aliases to index 0x05; hold mem_r five cycles past ready.
        ifa.mem_r = 1'b1; ifa.line_addr = 28'h105;
        tick();
        chk1("r_busy_hiz", relz(md_a), 1'b1);
        tick();
        tick();
        chk1("r_n2", ifa.ready, 1'b0);
        tick();
        chk1 ("r_ready", ifa.ready, 1'b1);
        chkl ("r_data",  md_a, DATA_D);
        chk16("r_rd_count", ifa.rd_count, 16'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("r_hold_ready", ifa.ready, 1'b0);
            chkl("r_hold_data",  md_a, DATA_D);
        end
        ifa.mem_r = 1'b0;
        tick();
        chk1 ("r_released", relz(md_a), 1'b1);
        chk16("r_no_reaccept", ifa.rd_count, 16'd1);

        // Both requests high in IDLE: no accept, sticky error.
        ifa.mem_r = 1'b1; ifa.mem_w = 1'b1;
        tick();
        chk1("both_err", ifa.err, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("both_no_ready", ifa.ready, 1'b0);
        end
        ifa.mem_r = 1'b0; ifa.mem_w = 1'b0;
        repeat (2) tick();
        chk1 ("err_sticky", ifa.err, 1'b1);
        chk16("both_wr_count", ifa.wr_count, 16'd1);
        chk16("both_rd_count", ifa.rd_count, 16'd1);

        // Reset one cycle after accepting a write to 0x07.
        ifa.mem_w = 1'b1; ifa.line_addr = 28'h007; dat_a = DATA_E; drv_a = 1'b1;
        tick();
        drv_a = 1'b0;
        tick();
        rst = 1'b1; ifa.mem_w = 1'b0;
        #1;
        chk1 ("arst_err",   ifa.err, 1'b0);
        chk16("arst_wr",    ifa.wr_count, 16'd0);
        chk16("arst_rd",    ifa.rd_count, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("arst_no_ready", ifa.ready, 1'b0);
        end
        chk16("arst_no_commit", ifa.wr_count, 16'd0);

        ifa.mem_r = 1'b1; ifa.line_addr = 28'h007;
        repeat (4) tick();
        chk1 ("r7_ready", ifa.ready, 1'b1);
        chkl ("r7_zero",  md_a, '0);
        chk16("r7_rd_count", ifa.rd_count, 16'd1);
        ifa.mem_r = 1'b0;
        repeat (2) tick();

        // Storage survives reset.
        ifa.mem_r = 1'b1; ifa.line_addr = 28'h005;
        repeat (4) tick();
        chk1("r5_ready", ifa.ready, 1'b1);
        chkl("r5_kept",  md_a, DATA_D);
        ifa.mem_r = 1'b0;
        repeat (2) tick();
        chk1("r5_released", relz(md_a), 1'b1);

        // LATENCY=1 instance: ready on the edge after accept.
        write_b(28'h003, DATA_F, "l1_w");
        chk16("l1_wr_count", ifb.wr_count, 16'd1);

        // Counter wrap: preload near the top while idle, then two writes.
        force u_dut_b.wr_cnt_q = 16'hFFFE;
        tick();
        release u_dut_b.wr_cnt_q;
        tick();
        chk16("wrap_preload", ifb.wr_count, 16'hFFFE);
        write_b(28'h004, DATA_E, "wrap_w1");
        chk16("wrap_ffff", ifb.wr_count, 16'hFFFF);
        write_b(28'h005, DATA_D, "wrap_w2");
        chk16("wrap_zero", ifb.wr_count, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
